uart_cmd_bridge: RTL and testbench

Byte-stream command bridge between the UART RX FIFO and TX FIFO of the user-project UART. It consumes framed binary commands from the RX FIFO output, executes one 32-bit Wishbone master read or write per frame, and pushes a framed response into the TX FIFO input. This lets a host on mprj_io drive the 0x3000_0000 user address space through the serial link alone.

---
 rtl/uart_cmd_bridge_pkg.sv | 43 ++++
 rtl/uart_cmd_bridge_if.sv | 21 ++
 rtl/uart_cmd_bridge_wbm.sv | 71 +++++++
 rtl/uart_cmd_bridge.sv | 195 +++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_bridge_pkg.sv
// Shared constants, FSM state type and response helper for the UART command bridge.
// Optional feature macro: UART_CMD_CHKSUM_EN (adds a trailing XOR checksum byte per frame).
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic [7:0] RESP_BYTE      = 8'h5A;

  localparam logic [7:0] CMD_READ       = 8'h01;
  localparam logic [7:0] CMD_WRITE      = 8'h02;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h01;
  localparam logic [7:0] STATUS_BAD_CMD = 8'h02;
  localparam logic [7:0] STATUS_CHKSUM  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
`ifdef UART_CMD_CHKSUM_EN
    ST_CHK,
`endif
    ST_BUS,
    ST_RESP
  } state_t;

  // Byte idx of a response frame: sync, status, then read data big-endian.
  function automatic logic [7:0] resp_byte(logic [2:0] idx, logic [7:0] status,
                                           logic [31:0] data);
    logic [7:0] b;
    case (idx)
      3'd0:    b = RESP_BYTE;
      3'd1:    b = status;
      3'd2:    b = data[31:24];
      3'd3:    b = data[23:16];
      3'd4:    b = data[15:8];
      default: b = data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_bridge_if.sv
// Wishbone master bus bundle between the command bridge and the user-area interconnect.
interface uart_cmd_bridge_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/uart_cmd_bridge_wbm.sv
// Single-transaction Wishbone master with an ack timeout; started by a one-cycle
// start pulse, reports completion with a one-cycle done pulse plus status/rdata.
module uart_cmd_wbm
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    we,
  input  logic [31:0]             adr,
  input  logic [31:0]             wdata,
  output logic                    done,
  output logic [7:0]              status,
  output logic [31:0]             rdata,
  uart_cmd_bridge_if.master       wb
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Launch a cycle on start, then end it on ack (priority) or on counter expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wbm_cyc_o <= 1'b0;
      wb.wbm_stb_o <= 1'b0;
      wb.wbm_we_o  <= 1'b0;
      wb.wbm_sel_o <= 4'h0;
      wb.wbm_adr_o <= 32'h0;
      wb.wbm_dat_o <= 32'h0;
      count        <= 16'h0;
      done         <= 1'b0;
      status       <= STATUS_OK;
      rdata        <= 32'h0;
    end else begin
      done <= 1'b0;
      if (wb.wbm_cyc_o) begin
        if (wb.wbm_ack_i) begin
          wb.wbm_cyc_o <= 1'b0;
          wb.wbm_stb_o <= 1'b0;
          wb.wbm_we_o  <= 1'b0;
          wb.wbm_sel_o <= 4'h0;
          rdata        <= wb.wbm_dat_i;
          status       <= STATUS_OK;
          done         <= 1'b1;
        end else if (count == LAST_COUNT) begin
          wb.wbm_cyc_o <= 1'b0;
          wb.wbm_stb_o <= 1'b0;
          wb.wbm_we_o  <= 1'b0;
          wb.wbm_sel_o <= 4'h0;
          rdata        <= 32'h0;
          status       <= STATUS_TIMEOUT;
          done         <= 1'b1;
        end else begin
          count <= count + 16'd1;
        end
      end else if (start) begin
        wb.wbm_cyc_o <= 1'b1;
        wb.wbm_stb_o <= 1'b1;
        wb.wbm_we_o  <= we;
        wb.wbm_sel_o <= 4'hF;
        wb.wbm_adr_o <= adr;
        wb.wbm_dat_o <= wdata;
        count        <= 16'h0;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART byte-stream to Wishbone command bridge: parses A5-framed read/write
// commands from the RX FIFO, runs one bus transaction, answers through the TX FIFO.
// Optional feature macro: UART_CMD_CHKSUM_EN (trailing XOR checksum byte).
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_clear,
  input  logic              tx_busy,
  uart_cmd_bridge_if.master wb
);

  state_t      state;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  byte_idx;
  logic [7:0]  resp_status;
  logic [31:0] resp_data;
  logic [2:0]  resp_len;
  logic [2:0]  resp_idx;
  logic        bus_start;
  logic        bus_done;
  logic [7:0]  bus_status;
  logic [31:0] bus_rdata;
  logic        rx_take;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]  chk;
`endif

  // The FIFO head is stale in the cycle our pop is being applied, so skip it.
  assign rx_take = rx_valid && !rx_pop;

  uart_cmd_wbm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wbm (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus_start),
    .we     (cmd == CMD_WRITE),
    .adr    (addr),
    .wdata  (wdata),
    .done   (bus_done),
    .status (bus_status),
    .rdata  (bus_rdata),
    .wb     (wb)
  );

  // Frame parser, bus launch and byte-at-a-time response sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd         <= 8'h0;
      addr        <= 32'h0;
      wdata       <= 32'h0;
      byte_idx    <= 2'd0;
      resp_status <= STATUS_OK;
      resp_data   <= 32'h0;
      resp_len    <= 3'd0;
      resp_idx    <= 3'd0;
      bus_start   <= 1'b0;
      rx_pop      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h0;
`ifdef UART_CMD_CHKSUM_EN
      chk         <= 8'h0;
`endif
    end else begin
      rx_pop    <= 1'b0;
      bus_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_take) begin
            rx_pop <= 1'b1;
            if (rx_data == SYNC_BYTE) state <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (rx_take) begin
            rx_pop   <= 1'b1;
            cmd      <= rx_data;
            byte_idx <= 2'd0;
`ifdef UART_CMD_CHKSUM_EN
            chk      <= rx_data;
`endif
            if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
              state <= ST_ADDR;
            end else begin
              resp_status <= STATUS_BAD_CMD;
              resp_data   <= 32'h0;
              resp_len    <= 3'd2;
              resp_idx    <= 3'd0;
              state       <= ST_RESP;
            end
          end
        end

        ST_ADDR: begin
          if (rx_take) begin
            rx_pop   <= 1'b1;
            addr     <= {addr[23:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef UART_CMD_CHKSUM_EN
            chk      <= chk ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              if (cmd == CMD_WRITE) begin
                state <= ST_DATA;
              end else begin
`ifdef UART_CMD_CHKSUM_EN
                state <= ST_CHK;
`else
                state     <= ST_BUS;
                bus_start <= 1'b1;
`endif
              end
            end
          end
        end

        ST_DATA: begin
          if (rx_take) begin
            rx_pop   <= 1'b1;
            wdata    <= {wdata[23:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef UART_CMD_CHKSUM_EN
            chk      <= chk ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
`ifdef UART_CMD_CHKSUM_EN
              state <= ST_CHK;
`else
              state     <= ST_BUS;
              bus_start <= 1'b1;
`endif
            end
          end
        end

`ifdef UART_CMD_CHKSUM_EN
        ST_CHK: begin
          if (rx_take) begin
            rx_pop <= 1'b1;
            if (rx_data == chk) begin
              state     <= ST_BUS;
              bus_start <= 1'b1;
            end else begin
              resp_status <= STATUS_CHKSUM;
              resp_data   <= 32'h0;
              resp_len    <= (cmd == CMD_READ) ? 3'd6 : 3'd2;
              resp_idx    <= 3'd0;
              state       <= ST_RESP;
            end
          end
        end
`endif

        ST_BUS: begin
          if (bus_done) begin
            resp_status <= bus_status;
            resp_data   <= bus_rdata;
            resp_len    <= (cmd == CMD_READ) ? 3'd6 : 3'd2;
            resp_idx    <= 3'd0;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (tx_start) begin
            if (tx_clear) begin
              tx_start <= 1'b0;
              resp_idx <= resp_idx + 3'd1;
              if (resp_idx == resp_len - 3'd1) state <= ST_IDLE;
            end
          end else if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= resp_byte(resp_idx, resp_status, resp_data);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: RX FIFO model, TX FIFO sink with
// response scoreboard, Wishbone slave with programmable ack delay.
// Honours UART_CMD_CHKSUM_EN by appending checksum bytes and adding checksum vectors.
module tb_uart_cmd_bridge;
  import uart_cmd_pkg::*;

  localparam int TIMEOUT = 16;
  localparam logic [31:0] JUNK_DATA = 32'hBAD0_BAD0;

  typedef struct {
    logic [15:0] junk;
    int          njunk;
    logic [7:0]  cmd;
    logic [31:0] adr;
    logic [31:0] dat;
    int          ack_dly;
    logic [31:0] srd;
    bit          badchk;
    logic [7:0]  exp_status;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h0;
  logic       rx_valid = 1'b0;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_clear = 1'b0;
  logic       tx_busy = 1'b0;

  uart_cmd_bridge_if wb ();

  uart_cmd_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_clear (tx_clear),
    .tx_busy  (tx_busy),
    .wb       (wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  wb_txn_t    wb_exp[$];
  wb_txn_t    slave_txn;
  vec_t       vecs[$];

  int          ack_delay = -1;
  logic [31:0] slave_rdata = 32'h0;
  int          cyc_len = 0;
  int          cyc_len_last = 0;
  int          wait_cnt = 0;
  bit          in_txn = 1'b0;
  bit          prev_pop = 1'b0;
  int          pop_violations = 0;
  int          busy_violations = 0;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void refreshRx();
    rx_valid = (rx_q.size() != 0);
    rx_data  = rx_valid ? rx_q[0] : 8'h00;
  endfunction

  function automatic void pushByte(logic [7:0] b);
    rx_q.push_back(b);
    refreshRx();
  endfunction

  function automatic vec_t mkVec(logic [15:0] junk, int njunk, logic [7:0] cmd,
                                 logic [31:0] adr, logic [31:0] dat, int dly,
                                 logic [31:0] srd, bit badchk, logic [7:0] st, int cyc);
    vec_t v;
    v.junk = junk; v.njunk = njunk; v.cmd = cmd; v.adr = adr; v.dat = dat;
    v.ack_dly = dly; v.srd = srd; v.badchk = badchk; v.exp_status = st; v.exp_cyc = cyc;
    return v;
  endfunction

  // RX FIFO model: a pop applies mid-cycle, head refreshes before the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pop = 1'b0;
    end else begin
      if (rx_pop) begin
        if (prev_pop || rx_q.size() == 0) pop_violations++;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
      end
      prev_pop = rx_pop;
    end
    refreshRx();
  end

  // TX FIFO sink: accept each pushed byte with a one-cycle clear and score it
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_clear = 1'b0;
    end else if (tx_clear) begin
      tx_clear = 1'b0;
    end else if (tx_start) begin
      if (tx_busy) busy_violations++;
      if (tx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL tx_extra: got byte 0x%0h, expected no byte", tx_data);
      end else begin
        checkOutput("tx_byte", 32'(tx_data), 32'(tx_exp.pop_front()));
      end
      tx_clear = 1'b1;
    end
  end

  // Wishbone slave: check each new cycle, ack after ack_delay cycles (never if negative)
  always @(negedge clk) begin
    if (!rst_n || !wb.wbm_cyc_o) begin
      if (in_txn) cyc_len_last = cyc_len;
      in_txn        = 1'b0;
      wait_cnt      = 0;
      wb.wbm_ack_i  = 1'b0;
      wb.wbm_dat_i  = JUNK_DATA;
    end else begin
      if (!in_txn) begin
        in_txn  = 1'b1;
        cyc_len = 0;
        if (wb_exp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL wb_unexpected: got cycle at 0x%0h, expected no bus cycle",
                   wb.wbm_adr_o);
        end else begin
          slave_txn = wb_exp.pop_front();
          checkOutput("wb_we",  32'(wb.wbm_we_o),  32'(slave_txn.we));
          checkOutput("wb_adr", wb.wbm_adr_o,      slave_txn.adr);
          checkOutput("wb_sel", 32'(wb.wbm_sel_o), 32'h0000_000F);
          checkOutput("wb_stb", 32'(wb.wbm_stb_o), 32'h1);
          if (slave_txn.we) checkOutput("wb_dat", wb.wbm_dat_o, slave_txn.dat);
        end
      end
      cyc_len++;
      if (wb.wbm_ack_i) begin
        wb.wbm_ack_i = 1'b0;
        wb.wbm_dat_i = JUNK_DATA;
      end else if (ack_delay >= 0 && wait_cnt == ack_delay) begin
        wb.wbm_ack_i = 1'b1;
        wb.wbm_dat_i = slave_rdata;
      end
      wait_cnt++;
    end
  end

  task automatic pushFrame(vec_t v);
    logic [7:0] chk;
    logic [7:0] b;
    for (int j = v.njunk - 1; j >= 0; j--) pushByte(v.junk[j*8 +: 8]);
    pushByte(SYNC_BYTE);
    pushByte(v.cmd);
    chk = v.cmd;
    if (v.cmd == CMD_READ || v.cmd == CMD_WRITE) begin
      for (int k = 3; k >= 0; k--) begin
        b = v.adr[k*8 +: 8];
        pushByte(b);
        chk = chk ^ b;
      end
      if (v.cmd == CMD_WRITE) begin
        for (int k = 3; k >= 0; k--) begin
          b = v.dat[k*8 +: 8];
          pushByte(b);
          chk = chk ^ b;
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      pushByte(v.badchk ? ~chk : chk);
`endif
    end
  endtask

  // Queue expected bus cycle and response bytes, then feed the frame
  task automatic applyStimulus(vec_t v);
    logic [31:0] rd;
    ack_delay    = v.ack_dly;
    slave_rdata  = v.srd;
    cyc_len_last = 0;
    tx_exp.push_back(RESP_BYTE);
    tx_exp.push_back(v.exp_status);
    if (v.cmd == CMD_READ) begin
      rd = (v.exp_status == STATUS_OK) ? v.srd : 32'h0;
      for (int k = 3; k >= 0; k--) tx_exp.push_back(rd[k*8 +: 8]);
    end
    if ((v.cmd == CMD_READ || v.cmd == CMD_WRITE) && v.exp_status != STATUS_CHKSUM)
      wb_exp.push_back('{we: (v.cmd == CMD_WRITE), adr: v.adr, dat: v.dat});
    pushFrame(v);
  endtask

  task automatic waitIdle(string name, int budget);
    int n = 0;
    while (!(tx_exp.size() == 0 && rx_q.size() == 0 && wb_exp.size() == 0 &&
             !wb.wbm_cyc_o && !tx_start) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL %s: got no completion in %0d cycles (tx left %0d, wb left %0d), expected completion",
               name, budget, tx_exp.size(), wb_exp.size());
      tx_exp.delete();
      wb_exp.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_rx_pop"},   32'(rx_pop),        32'h0);
    checkOutput({tag, "_tx_start"}, 32'(tx_start),      32'h0);
    checkOutput({tag, "_tx_data"},  32'(tx_data),       32'h0);
    checkOutput({tag, "_cyc"},      32'(wb.wbm_cyc_o),  32'h0);
    checkOutput({tag, "_stb"},      32'(wb.wbm_stb_o),  32'h0);
    checkOutput({tag, "_we"},       32'(wb.wbm_we_o),   32'h0);
    checkOutput({tag, "_sel"},      32'(wb.wbm_sel_o),  32'h0);
    checkOutput({tag, "_adr"},      wb.wbm_adr_o,       32'h0);
    checkOutput({tag, "_dat"},      wb.wbm_dat_o,       32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   n;

    wb.wbm_ack_i = 1'b0;
    wb.wbm_dat_i = JUNK_DATA;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // junk, njunk, cmd, adr, dat, ack delay, slave rdata, badchk, status, cyc length
    vecs.push_back(mkVec(16'h0,    0, 8'h02, 32'h3000_0004, 32'hDEAD_BEEF,  0, 32'h0,         0, 8'h00,  1));
    vecs.push_back(mkVec(16'h0,    0, 8'h01, 32'h3000_0008, 32'h0,          3, 32'h1234_5678, 0, 8'h00,  4));
    vecs.push_back(mkVec(16'h0,    0, 8'h01, 32'h3000_0010, 32'h0,         -1, 32'h1111_1111, 0, 8'h01, 16));
    vecs.push_back(mkVec(16'h00FF, 2, 8'h07, 32'h0,         32'h0,          0, 32'h0,         0, 8'h02,  0));
    vecs.push_back(mkVec(16'h0,    0, 8'h01, 32'h3000_0020, 32'h0,         15, 32'hCAFE_F00D, 0, 8'h00, 16));
    vecs.push_back(mkVec(16'h0,    0, 8'h01, 32'h3000_0024, 32'h0,         16, 32'h5555_5555, 0, 8'h01, 16));
    vecs.push_back(mkVec(16'h0,    0, 8'h02, 32'hFFFF_FFFF, 32'h0000_0000,  1, 32'h0,         0, 8'h00,  2));
    vecs.push_back(mkVec(16'h005A, 1, 8'h00, 32'h0,         32'h0,          0, 32'h0,         0, 8'h02,  0));
    vecs.push_back(mkVec(16'h0,    0, 8'h02, 32'h3000_0000, 32'hA5A5_A5A5,  2, 32'h0,         0, 8'h00,  3));
`ifdef UART_CMD_CHKSUM_EN
    vecs.push_back(mkVec(16'h0,    0, 8'h02, 32'h3000_0000, 32'h0000_0001,  0, 32'h0,         1, 8'h03,  0));
    vecs.push_back(mkVec(16'h0,    0, 8'h01, 32'h3000_0030, 32'h0,          0, 32'h7777_7777, 1, 8'h03,  0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      waitIdle($sformatf("vec%0d_done", i), 400);
      checkOutput($sformatf("vec%0d_cyc_len", i), 32'(cyc_len_last), 32'(vecs[i].exp_cyc));
    end

    // TX backpressure: response must wait for tx_busy to drop, bytes intact
    tx_busy = 1'b1;
    applyStimulus(mkVec(16'h0, 0, 8'h01, 32'h3000_0044, 32'h0, 2, 32'h0BAD_F00D, 0, 8'h00, 3));
    repeat (50) @(posedge clk);
    #1;
    checkOutput("busy_no_start", 32'(busy_violations), 32'h0);
    checkOutput("busy_bytes_held", 32'(tx_exp.size()), 32'd6);
    tx_busy = 1'b0;
    waitIdle("busy_done", 400);

    // Reset mid-ADDR: partial frame lost, next frame parses cleanly
    pushByte(SYNC_BYTE);
    pushByte(CMD_WRITE);
    pushByte(8'h30);
    pushByte(8'h00);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_addr");
    rx_q.delete();
    refreshRx();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(mkVec(16'h0, 0, 8'h02, 32'h3000_0050, 32'h0102_0304, 1, 32'h0, 0, 8'h00, 2));
    waitIdle("rst_addr_next", 400);
    checkOutput("rst_addr_next_cyc", 32'(cyc_len_last), 32'd2);

    // Reset mid-bus: cycle drops asynchronously, then a read completes
    ack_delay = -1;
    v = mkVec(16'h0, 0, 8'h01, 32'h3000_0060, 32'h0, -1, 32'h0, 0, 8'h01, 16);
    wb_exp.push_back('{we: 1'b0, adr: v.adr, dat: 32'h0});
    pushFrame(v);
    n = 0;
    while (!wb.wbm_cyc_o && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("rst_bus_cyc_seen", 32'(wb.wbm_cyc_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_bus");
    tx_exp.delete();
    wb_exp.delete();
    rx_q.delete();
    refreshRx();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(mkVec(16'h0, 0, 8'h01, 32'h3000_0064, 32'h0, 0, 32'h89AB_CDEF, 0, 8'h00, 1));
    waitIdle("rst_bus_next", 400);
    checkOutput("rst_bus_next_cyc", 32'(cyc_len_last), 32'd1);

    checkOutput("rx_pop_protocol", 32'(pop_violations), 32'h0);
    checkOutput("tx_busy_protocol", 32'(busy_violations), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
